// File: rtl/pdp1_ram_arbiter.sv
// pdp1_ram_arbiter: CPU/loader arbiter for the single-port main RAM (optional fairness: PDP1_RAM_ARB_FAIRNESS_EN)
module pdp1_ram_arbiter #(
  parameter int unsigned MAX_CPU_STREAK = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [11:0] cpu_addr,
  input  logic [17:0] cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_ack,
  output logic [17:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic [11:0] ldr_addr,
  input  logic [17:0] ldr_wdata,
  input  logic        ldr_we,
  output logic        ldr_ack,
  output logic [17:0] ldr_rdata,
  output logic [11:0] ram_address,
  output logic [17:0] ram_data,
  output logic        ram_wren,
  input  logic [17:0] ram_q,
  output logic        busy,
  output logic        owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state;
  logic grant_ldr;
  if (MAX_CPU_STREAK < 1 || MAX_CPU_STREAK > 15) begin : g_bad_streak
    $error("MAX_CPU_STREAK must be in 1..15");
  end
`ifdef PDP1_RAM_ARB_FAIRNESS_EN
  localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_STREAK);
  logic [3:0] streak;
  assign grant_ldr = ldr_req && (!cpu_req || streak == STREAK_MAX);
  // count consecutive CPU wins while the loader waits; any loader win or idle loader clears it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) streak <= '0;
    else if (state == IDLE) streak <= (!ldr_req || grant_ldr) ? 4'd0 : streak + 4'd1;
`else
  assign grant_ldr = ldr_req && !cpu_req;
`endif
  assign busy = state != IDLE;
  // transaction sequencer: grant and latch RAM controls, issue, capture read data, acknowledge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      cpu_ack     <= 1'b0;
      ldr_ack     <= 1'b0;
      cpu_rdata   <= '0;
      ldr_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req || ldr_req) begin
          owner       <= grant_ldr;
          ram_address <= grant_ldr ? ldr_addr : cpu_addr;
          ram_data    <= grant_ldr ? ldr_wdata : cpu_wdata;
          ram_wren    <= grant_ldr ? ldr_we : cpu_we;
          state       <= ISSUE;
        end
        ISSUE: begin
          ram_wren <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (owner) begin
            ldr_rdata <= ram_q;
            ldr_ack   <= 1'b1;
          end else begin
            cpu_rdata <= ram_q;
            cpu_ack   <= 1'b1;
          end
          state <= ACK;
        end
        default: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_pdp1_ram_arbiter.sv
// tb_pdp1_ram_arbiter: directed self-checking bench for pdp1_ram_arbiter with a behavioural synchronous RAM
module tb_pdp1_ram_arbiter;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [11:0] cpu_addr;
  logic [17:0] cpu_wdata, cpu_rdata;
  logic        ldr_req, ldr_we, ldr_ack;
  logic [11:0] ldr_addr;
  logic [17:0] ldr_wdata, ldr_rdata;
  logic [11:0] ram_address;
  logic [17:0] ram_data, ram_q;
  logic        ram_wren, busy, owner;
  logic [17:0] mem [4096];
  int total = 0;
  int bad = 0;
  int cpu_acks = 0;
  int ldr_acks = 0;
  int wren_cyc = 0;
  always #5 clock = ~clock;
  pdp1_ram_arbiter #(.MAX_CPU_STREAK(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_we(ldr_we),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .owner(owner)
  );
  // main RAM port A: write on wren, registered read-before-write data
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end
  // running event counts sampled mid-cycle
  always @(negedge clock) begin
    if (cpu_ack) cpu_acks++;
    if (ldr_ack) ldr_acks++;
    if (ram_wren) wren_cyc++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask
  task automatic txn(input bit ldr, input logic [11:0] a, input logic [17:0] d, input bit we, output int lat);
    if (ldr) begin
      ldr_req = 1'b1; ldr_addr = a; ldr_wdata = d; ldr_we = we;
    end else begin
      cpu_req = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_we = we;
    end
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!(ldr ? ldr_ack : cpu_ack) && lat < 20);
  endtask
  task automatic drop();
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    @(negedge clock);
  endtask
  initial begin
    int lat, n, w0, la;
    logic exp_l;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    ldr_req = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_we = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_ldr_ack", ldr_ack, 0);
    chk("rst_owner", owner, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ldr_rdata", ldr_rdata, 0);
    reset_n = 1'b1;
    txn(0, 12'o10, 18'o111111, 1'b1, lat); drop();
    chk("pre10_lat", lat, 3);
    txn(0, 12'o11, 18'o222222, 1'b1, lat); drop();
    txn(0, 12'o200, 18'o1234, 1'b1, lat); drop();
    w0 = wren_cyc;
    txn(0, 12'o100, 18'o777777, 1'b1, lat); drop();
    chk("wr100_lat", lat, 3);
    chk("wr100_wren_cycles", wren_cyc - w0, 1);
    txn(0, 12'o100, 18'o0, 1'b0, lat);
    chk("rd100_lat", lat, 3);
    chk("rd100_rdata", cpu_rdata, 18'o777777);
    chk("rd100_ldr_ack", ldr_ack, 0);
    drop();
    txn(0, 12'o10, 18'o0, 1'b0, lat);
    chk("b2b_first_lat", lat, 3);
    chk("b2b_first_rdata", cpu_rdata, 18'o111111);
    txn(0, 12'o11, 18'o0, 1'b0, lat);
    chk("b2b_second_gap", lat, 4);
    chk("b2b_second_rdata", cpu_rdata, 18'o222222);
    drop();
    cpu_req = 1'b1; cpu_addr = 12'o200; cpu_we = 1'b0;
    ldr_req = 1'b1; ldr_addr = 12'o100; ldr_we = 1'b0;
    @(negedge clock);
    chk("both_owner_cpu", owner, 0);
    chk("both_addr_cpu", ram_address, 12'o200);
    chk("both_busy", busy, 1);
    repeat (2) @(negedge clock);
    chk("both_cpu_ack", cpu_ack, 1);
    chk("both_ldr_ack_low", ldr_ack, 0);
    chk("both_cpu_rdata", cpu_rdata, 18'o1234);
    cpu_req = 1'b0;
    txn(1, 12'o100, 18'o0, 1'b0, lat);
    chk("both_ldr_gap", lat, 4);
    chk("both_owner_ldr", owner, 1);
    chk("both_ldr_rdata", ldr_rdata, 18'o777777);
    chk("both_cpu_ack_low", cpu_ack, 0);
    drop();
    la = ldr_acks;
    cpu_req = 1'b1; cpu_addr = 12'o10; cpu_we = 1'b0;
    @(negedge clock);
    ldr_req = 1'b1; ldr_addr = 12'o11;
    @(negedge clock);
    ldr_req = 1'b0;
    @(negedge clock);
    chk("drop_cpu_ack", cpu_ack, 1);
    cpu_req = 1'b0;
    repeat (8) @(negedge clock);
    chk("drop_no_ldr_ack", ldr_acks - la, 0);
    chk("drop_idle", busy, 0);
    chk("drop_ldr_rdata_kept", ldr_rdata, 18'o777777);
    cpu_req = 1'b1; cpu_addr = 12'o10; cpu_we = 1'b0;
    ldr_req = 1'b1; ldr_addr = 12'o11; ldr_we = 1'b0;
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (cpu_ack || ldr_ack) begin
`ifdef PDP1_RAM_ARB_FAIRNESS_EN
        exp_l = (n % 5) == 4;
`else
        exp_l = 1'b0;
`endif
        chk("arb_order_ldr", ldr_ack, exp_l);
        chk("arb_order_cpu", cpu_ack, !exp_l);
        n++;
      end
    end
    chk("arb_grant_count", n, 20);
    drop();
    repeat (2) @(negedge clock);
    ldr_req = 1'b1; ldr_addr = 12'o200; ldr_wdata = 18'o5555; ldr_we = 1'b1;
    @(negedge clock);
    chk("abort_issue_wren", ram_wren, 1);
    chk("abort_issue_owner", owner, 1);
    la = ldr_acks;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_wren_low", ram_wren, 0);
    chk("abort_busy_low", busy, 0);
    ldr_req = 1'b0; ldr_we = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("abort_no_ldr_ack", ldr_acks - la, 0);
    txn(0, 12'o200, 18'o0, 1'b0, lat);
    chk("abort_rd_lat", lat, 3);
    chk("abort_rd_old", cpu_rdata, 18'o1234);
    drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
